// File: rtl/async_receiver_if.sv
// Serial line plus parallel receive-side outputs of the UART receiver.
// The slave modport belongs to the receiver; master is the line/consumer side.
interface async_receiver_if;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;

    modport slave (
        input  RxD,
        output RxD_data,
        output RxD_data_ready,
        output RxD_frame_err,
        output RxD_busy
    );

    modport master (
        output RxD,
        input  RxD_data,
        input  RxD_data_ready,
        input  RxD_frame_err,
        input  RxD_busy
    );
endinterface

// File: rtl/async_receiver.sv
// UART 8N1 receiver: oversampled, majority-filtered RxD, mid-bit sampling,
// one-cycle strobes for a good byte or a bad stop bit.
module async_receiver #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic            clk,
    input  logic            rst,
    async_receiver_if.slave rx
);
    localparam int DIV = ClkFrequency / (Baud * Oversampling);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(Oversampling);

    generate
        if (DIV < 1 || Oversampling < 4 || (Oversampling % 2) != 0) begin : g_bad_param
            $error("async_receiver: DIV must be >= 1 and Oversampling even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q;
    logic            tick;
    logic [1:0]      sync_q;
    logic [2:0]      hist_q;
    logic            rx_bit;
    logic [OW-1:0]   os_cnt_q, os_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    assign tick   = (div_cnt_q == DW'(DIV - 1));
    assign rx_bit = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    // Synchroniser and filter history reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            sync_q    <= 2'b11;
            hist_q    <= 3'b111;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + DW'(1);
            sync_q    <= {sync_q[0], rx.RxD};
            if (tick)
                hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d  = START;
                        os_cnt_d = OW'(1);
                    end
                end
                START: begin
                    // Half a bit in, the line must still be low or it was a glitch.
                    if (os_cnt_q == OW'(Oversampling / 2)) begin
                        if (rx_bit) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            os_cnt_d  = '0;
                            bit_idx_d = '0;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
                DATA: begin
                    if (os_cnt_q == OW'(Oversampling - 1)) begin
                        shift_d  = {rx_bit, shift_q[7:1]};
                        os_cnt_d = '0;
                        if (bit_idx_q == 3'd7)
                            state_d = STOP;
                        else
                            bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
                STOP: begin
                    if (os_cnt_q == OW'(Oversampling - 1)) begin
                        os_cnt_d = '0;
                        if (rx_bit) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OW'(1);
                    end
                end
                BREAK: begin
                    // A line held low must return high before a new start is hunted.
                    if (rx_bit)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx.RxD_data       = data_q;
    assign rx.RxD_data_ready = ready_q;
    assign rx.RxD_frame_err  = err_q;
    assign rx.RxD_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver: drives 8N1 frames on RxD at nominal and
// skewed bit periods and checks strobes, data, busy and reset behaviour.
module tb_async_receiver;
    localparam int P    = 217;   // 25 MHz / 115200 bit/s, in clk cycles
    localparam int PFST = 213;   // baud +2%
    localparam int PSLW = 221;   // baud -2%

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    int         ready_cnt = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    logic       gap_seen  = 1'b0;
    logic       gap_at_ready = 1'b0;
    logic [7:0] data_log [0:63];

    async_receiver_if rx_if();

    async_receiver #(
        .ClkFrequency(25000000),
        .Baud(115200),
        .Oversampling(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx_if)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (rx_if.RxD_data_ready === 1'b1) begin
            data_log[6'(ready_cnt)] <= rx_if.RxD_data;
            ready_cnt    <= ready_cnt + 1;
            gap_at_ready <= gap_seen;
            gap_seen     <= 1'b0;
        end else if (rx_if.RxD_busy === 1'b0) begin
            gap_seen <= 1'b1;
        end
        if (rx_if.RxD_frame_err === 1'b1)
            err_cnt <= err_cnt + 1;
        if (rx_if.RxD_data_ready === 1'b1 && rx_if.RxD_frame_err === 1'b1)
            both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int nstop, input int p, input logic stop_v);
        rx_if.RxD = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_if.RxD = b[i];
            repeat (p) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_if.RxD = stop_v;
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic line_idle(input int nbits);
        rx_if.RxD = 1'b1;
        repeat (nbits * P) @(negedge clk);
    endtask

    initial begin
        int rb, eb;
        rst       = 1'b1;
        rx_if.RxD = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data",  32'(rx_if.RxD_data), 32'h0);
        chk("rst_ready", 32'(rx_if.RxD_data_ready), 32'h0);
        chk("rst_err",   32'(rx_if.RxD_frame_err), 32'h0);
        chk("rst_busy",  32'(rx_if.RxD_busy), 32'h0);
        rst = 1'b0;
        line_idle(2);

        // 1: single 0x55 frame
        rb = ready_cnt; eb = err_cnt;
        send_frame(8'h55, 1, P, 1'b1);
        line_idle(2);
        chk("t1_ready_cnt", 32'(ready_cnt - rb), 32'd1);
        chk("t1_data",      32'(rx_if.RxD_data), 32'h55);
        chk("t1_err_cnt",   32'(err_cnt - eb), 32'd0);
        chk("t1_busy",      32'(rx_if.RxD_busy), 32'h0);

        // 2: back-to-back frames with two stop bits, no idle gap
        rb = ready_cnt; eb = err_cnt;
        send_frame(8'hA5, 2, P, 1'b1);
        send_frame(8'h3C, 2, P, 1'b1);
        line_idle(2);
        chk("t2_ready_cnt", 32'(ready_cnt - rb), 32'd2);
        chk("t2_data0",     32'(data_log[6'(rb)]), 32'hA5);
        chk("t2_data1",     32'(data_log[6'(rb + 1)]), 32'h3C);
        chk("t2_busy_gap",  32'(gap_at_ready), 32'h1);
        chk("t2_err_cnt",   32'(err_cnt - eb), 32'd0);

        // 3: start glitch of Oversampling/2-2 = 2 ticks
        rb = ready_cnt; eb = err_cnt;
        rx_if.RxD = 1'b0;
        repeat (2 * 27) @(negedge clk);
        line_idle(2);
        chk("t3_ready_cnt", 32'(ready_cnt - rb), 32'd0);
        chk("t3_err_cnt",   32'(err_cnt - eb), 32'd0);
        chk("t3_busy",      32'(rx_if.RxD_busy), 32'h0);
        chk("t3_data",      32'(rx_if.RxD_data), 32'h3C);

        // 4: bad stop bit, line held low, then a good frame
        rb = ready_cnt; eb = err_cnt;
        send_frame(8'h00, 1, P, 1'b0);
        repeat (3 * P) @(negedge clk);
        chk("t4_err_cnt",   32'(err_cnt - eb), 32'd1);
        chk("t4_ready_cnt", 32'(ready_cnt - rb), 32'd0);
        chk("t4_data_kept", 32'(rx_if.RxD_data), 32'h3C);
        chk("t4_busy_brk",  32'(rx_if.RxD_busy), 32'h1);
        line_idle(2);
        chk("t4_busy_rel",  32'(rx_if.RxD_busy), 32'h0);
        send_frame(8'h81, 1, P, 1'b1);
        line_idle(2);
        chk("t4_ready_81",  32'(ready_cnt - rb), 32'd1);
        chk("t4_data_81",   32'(rx_if.RxD_data), 32'h81);
        chk("t4_err_after", 32'(err_cnt - eb), 32'd1);

        // 5: reset in the middle of bit 4 of 0xF0
        rb = ready_cnt; eb = err_cnt;
        rx_if.RxD = 1'b0;
        repeat (5 * P) @(negedge clk);
        rx_if.RxD = 1'b1;
        repeat (P / 2) @(negedge clk);
        chk("t5_busy_mid",  32'(rx_if.RxD_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_data",  32'(rx_if.RxD_data), 32'h0);
        chk("t5_rst_ready", 32'(rx_if.RxD_data_ready), 32'h0);
        chk("t5_rst_err",   32'(rx_if.RxD_frame_err), 32'h0);
        chk("t5_rst_busy",  32'(rx_if.RxD_busy), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (P / 2 + 4 * P) @(negedge clk);
        line_idle(2);
        chk("t5_no_strobe", 32'(ready_cnt - rb), 32'd0);
        chk("t5_no_err",    32'(err_cnt - eb), 32'd0);
        send_frame(8'h0F, 1, P, 1'b1);
        line_idle(2);
        chk("t5_ready_0f",  32'(ready_cnt - rb), 32'd1);
        chk("t5_data_0f",   32'(rx_if.RxD_data), 32'h0F);

        // 6: 0xC3 at +2% and -2% baud
        rb = ready_cnt; eb = err_cnt;
        send_frame(8'hC3, 1, PFST, 1'b1);
        line_idle(2);
        chk("t6_fast_ready", 32'(ready_cnt - rb), 32'd1);
        chk("t6_fast_data",  32'(rx_if.RxD_data), 32'hC3);
        chk("t6_fast_err",   32'(err_cnt - eb), 32'd0);
        rb = ready_cnt;
        send_frame(8'hC3, 1, PSLW, 1'b1);
        line_idle(2);
        chk("t6_slow_ready", 32'(ready_cnt - rb), 32'd1);
        chk("t6_slow_data",  32'(rx_if.RxD_data), 32'hC3);
        chk("t6_slow_err",   32'(err_cnt - eb), 32'd0);

        chk("ready_err_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
